// File: rtl/graph_pkg.sv
// Shared graph constants, route-line width and writer state encoding,
// used by the edge table writer and the route-search engine.
package graph_pkg;

    localparam int NUM_POINTS = 66;
    localparam int NUM_EDGES  = 1034;
    localparam int ADDR_W     = 11;
    localparam int PT_W       = 8;

    // Width of one route line in the edge RAM; the searcher uses the same value.
    localparam int ROUTE_W    = NUM_POINTS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } stateT;

endpackage

// File: rtl/edge_encoder.sv
// Maps an endpoint pair to its two-hot route line; out-of-range endpoints
// contribute no bit. valid flags a distinct, in-range pair.
module edge_encoder
    import graph_pkg::*;
(
    input  logic [PT_W-1:0]    ptA,
    input  logic [PT_W-1:0]    ptB,
    output logic [ROUTE_W-1:0] line,
    output logic               valid
);

    localparam logic [ROUTE_W-1:0] ONE      = ROUTE_W'(1);
    localparam logic [PT_W-1:0]    PT_LIMIT = PT_W'(NUM_POINTS);

    logic aIn;
    logic bIn;

    always_comb begin
        aIn  = (ptA < PT_LIMIT);
        bIn  = (ptB < PT_LIMIT);
        line = '0;
        if (aIn) line = line | (ONE << ptA);
        if (bIn) line = line | (ONE << ptB);
        valid = aIn && bIn && (ptA != ptB);
    end

endmodule

// File: rtl/edge_table_writer.sv
// Clears the edge RAM, then writes one route line per accepted edge and records
// its blocked flag in edge_mask. Optional edge validation: EDGE_CHECK_EN.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
// in_ready is a registered output that depends only on state, never on in_valid.
module edge_table_writer
    import graph_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PT_W-1:0]      in_pt_a,
    input  logic [PT_W-1:0]      in_pt_b,
    input  logic                 in_blocked,
    input  logic                 in_last,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [ROUTE_W-1:0]   ram_wdata,
    output logic [NUM_EDGES-1:0] edge_mask,
    output logic [ADDR_W-1:0]    edge_count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 bad_edge,
    output stateT                dbgState
);

    localparam logic [ADDR_W-1:0] EDGE_LIMIT = ADDR_W'(NUM_EDGES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_EDGES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    stateT              state;
    logic [ROUTE_W-1:0] line;
    logic               edgeOk;
    logic               accept;
    logic               keepEdge;

    edge_encoder u_encoder (
        .ptA   (in_pt_a),
        .ptB   (in_pt_b),
        .line  (line),
        .valid (edgeOk)
    );

    assign accept   = in_valid && in_ready;
    assign dbgState = state;

`ifdef EDGE_CHECK_EN
    assign keepEdge = edgeOk;
`else
    logic unusedEdgeOk;
    assign unusedEdgeOk = edgeOk;
    assign keepEdge     = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            edge_mask  <= '1;
            edge_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            bad_edge   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        edge_count <= '0;
                        overflow   <= 1'b0;
                        bad_edge   <= 1'b0;
                        edge_mask  <= '1;
                        ram_we     <= 1'b1;
                        ram_addr   <= '0;
                        ram_wdata  <= '0;
                    end
                end
                CLEAR: begin
                    // The final zero write is on the bus this cycle; LOAD opens next.
                    if (ram_addr == LAST_ADDR) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end else begin
                        ram_we   <= 1'b1;
                        ram_addr <= ram_addr + ADDR_ONE;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!keepEdge) begin
                            bad_edge <= 1'b1;
                        end else if (edge_count < EDGE_LIMIT) begin
                            ram_we                <= 1'b1;
                            ram_addr              <= edge_count;
                            ram_wdata             <= line;
                            edge_mask[edge_count] <= in_blocked;
                            edge_count            <= edge_count + ADDR_ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_table_writer.sv
// Bench for edge_table_writer: reference model of the edge list feeds an
// expected-write queue that a monitor drains as the RAM port writes.
module tb_edge_table_writer;
    import graph_pkg::*;

    localparam int NP = NUM_POINTS;
    localparam int NE = NUM_EDGES;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PT_W-1:0]      in_pt_a = '0;
    logic [PT_W-1:0]      in_pt_b = '0;
    logic                 in_blocked = 1'b0;
    logic                 in_last = 1'b0;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [NP-1:0]        ram_wdata;
    logic [NE-1:0]        edge_mask;
    logic [ADDR_W-1:0]    edge_count;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic                 bad_edge;
    stateT                dbgState;

    edge_table_writer dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pt_a(in_pt_a), .in_pt_b(in_pt_b),
        .in_blocked(in_blocked), .in_last(in_last),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .edge_mask(edge_mask), .edge_count(edge_count),
        .busy(busy), .done(done), .overflow(overflow), .bad_edge(bad_edge),
        .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W+NP-1:0] exp_q[$];
    logic [NP-1:0] tbRam [NE];
    bit monOn = 1'b0;

`ifdef EDGE_CHECK_EN
    bit checkEn = 1'b1;
`else
    bit checkEn = 1'b0;
`endif

    // reference model state for the current build
    int            mCount;
    logic [NE-1:0] mMask;
    bit            mOverflow;
    bit            mBad;

    always @(posedge clk) if (ram_we) tbRam[ram_addr] <= ram_wdata;

    task automatic checkVal(input string name, input logic [NE-1:0] act, input logic [NE-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] refLine(input int a, input int b);
        logic [NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p] = (p == a) || (p == b);
        return r;
    endfunction

    task automatic modelAccept(input int a, input int b, input bit blk);
        bit ok;
        ok = !checkEn || (a != b && a < NP && b < NP);
        if (!ok) mBad = 1'b1;
        else if (mCount < NE) begin
            exp_q.push_back({ADDR_W'(mCount), refLine(a, b)});
            mMask[mCount] = blk;
            mCount++;
        end else mOverflow = 1'b1;
    endtask

    // monitor: every LOAD-phase RAM write must match the head of the queue
    always @(negedge clk) begin
        if (monOn && ram_we) begin
            logic [ADDR_W+NP-1:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL ram_write_unexpected actual=%0d:%0h required=none", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL ram_write actual=%0d:%0h required=%0d:%0h",
                             ram_addr, ram_wdata, e[ADDR_W+NP-1:NP], e[NP-1:0]);
                end
            end
        end
    end

    task automatic checkReset();
        checkVal("rst_in_ready", in_ready, 0);
        checkVal("rst_ram_we", ram_we, 0);
        checkVal("rst_ram_addr", ram_addr, 0);
        checkVal("rst_ram_wdata", ram_wdata, 0);
        checkVal("rst_edge_mask", edge_mask, {NE{1'b1}});
        checkVal("rst_edge_count", edge_count, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_overflow", overflow, 0);
        checkVal("rst_bad_edge", bad_edge, 0);
    endtask

    // start a build and check the full clear sweep; a second start may be
    // pulsed at clear cycle restartAt (negative = none)
    task automatic doStart(input int restartAt);
        int clrErr = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            start = (i == restartAt);
            if (!(ram_we === 1'b1 && ram_addr === ADDR_W'(i) && ram_wdata === '0 &&
                  in_ready === 1'b0 && busy === 1'b1)) clrErr++;
        end
        @(negedge clk);
        start = 1'b0;
        checkVal("clear_sweep_errors", clrErr, 0);
        checkVal("load_ready_at_1035", in_ready, 1);
        checkVal("clear_zeroes_ram7", tbRam[7], 0);
        mCount = 0;
        mMask = '1;
        mOverflow = 1'b0;
        mBad = 1'b0;
        exp_q.delete();
        monOn = 1'b1;
    endtask

    task automatic sendBeat(input int a, input int b, input bit blk, input bit last, input int gap);
        bit rdy;
        bit acc = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_pt_a = PT_W'(a);
        in_pt_b = PT_W'(b);
        in_blocked = blk;
        in_last = last;
        for (int t = 0; t < 200; t++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                modelAccept(a, b, blk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept_timeout actual=0 required=1");
        end
    endtask

    task automatic finishBuild();
        int dirty = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        checkVal("done_early", done, 0);
        @(negedge clk);
        checkVal("done_pulse", done, 1);
        @(negedge clk);
        checkVal("done_width", done, 0);
        monOn = 1'b0;
        checkVal("edge_count", edge_count, mCount);
        checkVal("edge_mask", edge_mask, mMask);
        checkVal("overflow", overflow, mOverflow);
        checkVal("bad_edge", bad_edge, mBad);
        checkVal("busy_idle", busy, 0);
        checkVal("ready_idle", in_ready, 0);
        checkVal("writes_pending", exp_q.size(), 0);
        for (int i = mCount; i < NE; i++) if (tbRam[i] !== '0) dirty++;
        checkVal("unwritten_zero", dirty, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP-1:0] e;
        logic [NE-1:0] m;
        int n;
        for (int i = 0; i < NE; i++) tbRam[i] = '0;
        tbRam[7] = {NP{1'b1}};

        #12;
        checkReset();
        @(negedge clk);
        rst = 1'b0;
        checkVal("idle_ready", in_ready, 0);

        // basic load
        doStart(-1);
        sendBeat(0, 5, 1'b0, 1'b0, 0);
        sendBeat(5, 65, 1'b1, 1'b1, 0);
        finishBuild();
        e = '0; e[0] = 1'b1; e[5] = 1'b1;
        checkVal("basic_ram0", tbRam[0], e);
        e = '0; e[5] = 1'b1; e[65] = 1'b1;
        checkVal("basic_ram1", tbRam[1], e);
        m = '1; m[0] = 1'b0;
        checkVal("basic_mask", edge_mask, m);
        checkVal("basic_count", edge_count, 2);

        // backpressure and gaps
        tbRam[7] = {NP{1'b1}};
        doStart(-1);
        for (int i = 0; i < 20; i++)
            sendBeat($urandom_range(0, NP - 1), $urandom_range(0, NP - 1),
                     1'($urandom_range(0, 1)), i == 19, $urandom_range(0, 3));
        finishBuild();

        // degenerate and out-of-range endpoints
        doStart(-1);
        sendBeat(3, 3, 1'b0, 1'b0, 0);
        sendBeat(70, 2, 1'b0, 1'b0, 1);
        sendBeat(1, 2, 1'b0, 1'b1, 0);
        finishBuild();
        e = '0; e[1] = 1'b1; e[2] = 1'b1;
        if (checkEn) begin
            checkVal("chk_ram0", tbRam[0], e);
            checkVal("chk_count", edge_count, 1);
            checkVal("chk_bad", bad_edge, 1);
        end else begin
            checkVal("nochk_ram2", tbRam[2], e);
            checkVal("nochk_count", edge_count, 3);
            checkVal("nochk_bad", bad_edge, 0);
        end

        // overflow: 1036 edges, back to back
        doStart(-1);
        e = '0;
        for (int i = 0; i < NE + 2; i++) begin
            int a = $urandom_range(0, NP - 1);
            int b = (a + 1 + $urandom_range(0, NP - 2)) % NP;
            if (i == NE - 1) e = refLine(a, b);
            sendBeat(a, b, 1'($urandom_range(0, 1)), i == NE + 1, 0);
        end
        finishBuild();
        checkVal("ovf_count", edge_count, NE);
        checkVal("ovf_flag", overflow, 1);
        checkVal("ovf_ram1033", tbRam[NE - 1], e);

        // reset mid-LOAD
        doStart(-1);
        for (int i = 0; i < 5; i++) sendBeat(i, i + 10, 1'b1, 1'b0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkReset();
        monOn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // start pulsed during CLEAR must not restart the sweep
        doStart(500);
        n = $urandom_range(4, 12);
        for (int i = 0; i < n; i++)
            sendBeat($urandom_range(0, NP + 3), $urandom_range(0, NP + 3),
                     1'($urandom_range(0, 1)), i == n - 1, $urandom_range(0, 2));
        finishBuild();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
